// File: rtl/pkt_loader_pkg.sv
// -----------------------------------------------------------------------------
// pkt_loader_pkg
// Shared definitions for the packet loader: bus widths, the default packet
// buffer base address (also used by the header parser as its base offset),
// the loader state encoding and small lane helpers.
// -----------------------------------------------------------------------------
package pkt_loader_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;

  localparam logic       TRUE  = 1'b1;
  localparam logic       FALSE = 1'b0;

  // Byte address of packet byte 0; shared with the parser.
  localparam logic [ADDR_W-1:0] PKT_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    PKT_STATE_FREE  = 2'd0,
    PKT_STATE_RECV  = 2'd1,
    PKT_STATE_FLUSH = 2'd2,
    PKT_STATE_HOLD  = 2'd3
  } pkt_state_e;

  // Lane j is written by sel bit 3-j (bit 3 = lowest byte address).
  function automatic logic [LANES-1:0] lane_sel(input logic [1:0] lane);
    return 4'b1000 >> lane;
  endfunction

  // Lane j occupies data bits [31-8j : 24-8j] (big-endian packing).
  function automatic logic [DATA_W-1:0] lane_data(input logic [1:0] lane,
                                                  input logic [BYTE_W-1:0] b);
    return {b, 24'h00_0000} >> {lane, 3'b000};
  endfunction

endpackage

// File: rtl/pkt_loader_if.sv
// -----------------------------------------------------------------------------
// pkt_loader_if
// Groups the three buses of the packet loader:
//   rx_*   : ingress byte stream (valid/data/last in, ready out)
//   sram_* : single-cycle write port into the shared packet SRAM
//   pkt_*  : packet handoff to the header parser
// Modports:
//   master : the loader side (drives ready, SRAM and pkt_valid/len/trunc)
//   slave  : the environment side (byte source, SRAM, parser)
//
// Handshakes: a byte moves on a rising edge where rx_valid_i and rx_ready_o
// are both 1; rx_data_i/rx_last_i must be stable while rx_valid_i is 1 and
// ready is low. The packet handoff holds pkt_valid_o high (len/trunc stable)
// until the edge where pkt_ready_i is sampled 1, which releases the buffer.
// -----------------------------------------------------------------------------
interface pkt_loader_if #(
  parameter int LEN_W = 16
);
  logic             rx_valid_i;
  logic [7:0]       rx_data_i;
  logic             rx_last_i;
  logic             rx_ready_o;

  logic             sram_ce_o;
  logic             sram_we_o;
  logic [31:0]      sram_addr_o;
  logic [3:0]       sram_sel_o;
  logic [31:0]      sram_data_o;

  logic             pkt_valid_o;
  logic [LEN_W-1:0] pkt_len_o;
  logic             pkt_trunc_o;
  logic             pkt_ready_i;

  modport master (
    input  rx_valid_i, rx_data_i, rx_last_i, pkt_ready_i,
    output rx_ready_o,
    output sram_ce_o, sram_we_o, sram_addr_o, sram_sel_o, sram_data_o,
    output pkt_valid_o, pkt_len_o, pkt_trunc_o
  );

  modport slave (
    output rx_valid_i, rx_data_i, rx_last_i, pkt_ready_i,
    input  rx_ready_o,
    input  sram_ce_o, sram_we_o, sram_addr_o, sram_sel_o, sram_data_o,
    input  pkt_valid_o, pkt_len_o, pkt_trunc_o
  );
endinterface

// File: rtl/pkt_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// pkt_loader_byte_packer
// Packs transferred bytes big-endian into a 32-bit word. Holds the lane
// counter, the partial word buffer and the accumulated byte enables.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   i_xfer        : a byte transfers on this edge
//   i_data        : the byte
//   i_last        : the byte ends the packet
//   i_in_range    : the byte lies inside the buffer and may be stored
//   i_clear       : buffer released; restart at lane 0
//   o_wr          : this transfer closes a word that has bytes to write
//   o_word/o_sel  : complete word and its byte enables (valid with o_wr)
// -----------------------------------------------------------------------------
module pkt_loader_byte_packer
  import pkt_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_xfer,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_in_range,
  input  logic              i_clear,
  output logic              o_wr,
  output logic [DATA_W-1:0] o_word,
  output logic [LANES-1:0]  o_sel
);

  logic [1:0]        r_lane;
  logic [DATA_W-1:0] r_buf;
  logic [LANES-1:0]  r_sel;

  logic [LANES-1:0]  w_cur_sel;
  logic [DATA_W-1:0] w_cur_data;
  logic              w_close;

  // Out-of-range bytes still advance the lane but contribute nothing, so a
  // word straddling the capacity limit writes only its in-range lanes.
  assign w_cur_sel  = i_in_range ? lane_sel(r_lane) : '0;
  assign w_cur_data = i_in_range ? lane_data(r_lane, i_data) : '0;
  assign w_close    = i_xfer && ((r_lane == 2'd3) || i_last);

  assign o_word = r_buf | w_cur_data;
  assign o_sel  = r_sel | w_cur_sel;
  assign o_wr   = w_close && (o_sel != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane <= 2'd0;
      r_buf  <= '0;
      r_sel  <= '0;
    end else if (i_clear) begin
      r_lane <= 2'd0;
      r_buf  <= '0;
      r_sel  <= '0;
    end else if (i_xfer) begin
      if (w_close) begin
        r_buf  <= '0;
        r_sel  <= '0;
        r_lane <= i_last ? 2'd0 : (r_lane + 2'd1);
      end else begin
        r_buf  <= o_word;
        r_sel  <= o_sel;
        r_lane <= r_lane + 2'd1;
      end
    end
  end

endmodule

// File: rtl/pkt_loader.sv
// -----------------------------------------------------------------------------
// pkt_loader
// Receives an ingress byte stream, packs it big-endian into 32-bit words and
// writes them into the packet SRAM from BASE_ADDR. At end of packet it offers
// the buffer to the header parser (pkt_valid/pkt_ready) and back-pressures the
// ingress until the parser releases it: one packet in flight.
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   bus          : pkt_loader_if master (rx_*, sram_*, pkt_*)
//   dbg_state_o  : current FSM state
// All sram_* and pkt_* outputs are registered; rx_ready_o is a registered
// decode of the state, so nothing on rx_* reaches an output combinationally.
// -----------------------------------------------------------------------------
module pkt_loader
  import pkt_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = PKT_BASE_ADDR,
  parameter int          MAX_BYTES = 2048,
  parameter int          LEN_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  pkt_loader_if.master bus,
  output pkt_state_e  dbg_state_o
);

  localparam logic [31:0] MAX_U = 32'(MAX_BYTES);

  pkt_state_e        r_state;
  pkt_state_e        w_next;

  logic [LEN_W-1:0]  r_count;
  logic              r_ready;
  logic              r_ce;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [LANES-1:0]  r_sel;
  logic [DATA_W-1:0] r_data;
  logic              r_pkt_valid;
  logic [LEN_W-1:0]  r_pkt_len;
  logic              r_pkt_trunc;

  logic              w_xfer;
  logic              w_release;
  logic              w_in_range;
  logic              w_count_sat;
  logic              w_wr;
  logic [DATA_W-1:0] w_word;
  logic [LANES-1:0]  w_sel;
  logic [ADDR_W-1:0] w_word_addr;

  assign w_xfer      = bus.rx_valid_i && r_ready;
  assign w_release   = (r_state == PKT_STATE_HOLD) && bus.pkt_ready_i;
  assign w_in_range  = 32'(r_count) < MAX_U;
  assign w_count_sat = &r_count;
  // r_count is the index of the byte being transferred.
  assign w_word_addr = BASE_ADDR + (32'(r_count) & 32'hFFFF_FFFC);

  pkt_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_xfer     (w_xfer),
    .i_data     (bus.rx_data_i),
    .i_last     (bus.rx_last_i),
    .i_in_range (w_in_range),
    .i_clear    (w_release),
    .o_wr       (w_wr),
    .o_word     (w_word),
    .o_sel      (w_sel)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      PKT_STATE_FREE: begin
        if (w_xfer) w_next = bus.rx_last_i ? PKT_STATE_FLUSH : PKT_STATE_RECV;
      end
      PKT_STATE_RECV: begin
        if (w_xfer && bus.rx_last_i) w_next = PKT_STATE_FLUSH;
      end
      PKT_STATE_FLUSH: begin
        w_next = PKT_STATE_HOLD;
      end
      PKT_STATE_HOLD: begin
        if (bus.pkt_ready_i) w_next = PKT_STATE_FREE;
      end
      default: w_next = PKT_STATE_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= PKT_STATE_FREE;
      r_count     <= '0;
      r_ready     <= FALSE;
      r_ce        <= FALSE;
      r_we        <= FALSE;
      r_addr      <= BASE_ADDR;
      r_sel       <= '0;
      r_data      <= '0;
      r_pkt_valid <= FALSE;
      r_pkt_len   <= '0;
      r_pkt_trunc <= FALSE;
    end else begin
      r_state <= w_next;
      // Ready follows the state it is decoded from; it stays 0 while in reset.
      r_ready <= (w_next == PKT_STATE_FREE) || (w_next == PKT_STATE_RECV);

      r_ce <= w_wr;
      r_we <= w_wr;
      if (w_wr) begin
        r_addr <= w_word_addr;
        r_data <= w_word;
        r_sel  <= w_sel;
      end

      if (w_xfer && !w_count_sat) r_count <= r_count + LEN_W'(1);

      if (r_state == PKT_STATE_FLUSH) begin
        r_pkt_valid <= TRUE;
        r_pkt_len   <= r_count;
        r_pkt_trunc <= 32'(r_count) > MAX_U;
      end

      if (w_release) begin
        r_pkt_valid <= FALSE;
        r_count     <= '0;
      end
    end
  end

  assign bus.rx_ready_o  = r_ready;
  assign bus.sram_ce_o   = r_ce;
  assign bus.sram_we_o   = r_we;
  assign bus.sram_addr_o = r_addr;
  assign bus.sram_sel_o  = r_sel;
  assign bus.sram_data_o = r_data;
  assign bus.pkt_valid_o = r_pkt_valid;
  assign bus.pkt_len_o   = r_pkt_len;
  assign bus.pkt_trunc_o = r_pkt_trunc;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_pkt_loader.sv
// -----------------------------------------------------------------------------
// tb_pkt_loader
// Two loaders share one ingress stream: dut_a (base 0, 2048-byte buffer,
// 16-bit length) and dut_b (base 0x100, 8-byte buffer, 4-bit length, so both
// truncation and length saturation occur on short packets).
// -----------------------------------------------------------------------------
module tb_pkt_loader;
  import pkt_loader_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } wr_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pkt_loader_if #(.LEN_W(16)) if_a ();
  pkt_loader_if #(.LEN_W(4))  if_b ();
  pkt_state_e dbg_a, dbg_b;

  pkt_loader #(.BASE_ADDR(32'h0),   .MAX_BYTES(2048), .LEN_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a), .dbg_state_o(dbg_a));
  pkt_loader #(.BASE_ADDR(32'h100), .MAX_BYTES(8),    .LEN_W(4))  dut_b (
    .clk(clk), .rst(rst), .bus(if_b), .dbg_state_o(dbg_b));

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  int BASE[2]   = '{0, 32'h100};
  int MAXB[2]   = '{2048, 8};
  int LENMAX[2] = '{65535, 15};

  // Behavioural model: expected outputs after the next rising edge.
  logic       chk_en = 1'b0;
  logic       m_ready = 1'b0;   // ready seen by the source this cycle
  int         m_phase = 0;      // 0 accepting, 1 final write, 2 handed off
  int         m_t = 0;          // bytes transferred in this packet
  logic [7:0] pkt_q[$];
  logic       last_xfer;
  logic       e_we[2];
  int         e_addr[2];
  logic [31:0] e_data[2];
  logic [3:0] e_sel[2];
  logic       e_pv = 1'b0;
  int         e_len[2];
  logic       e_trunc[2];
  logic       e_ready = 1'b0;

  wr_t        log_a[$];
  wr_t        log_b[$];
  logic [7:0] tx_q[$];
  logic       tog = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("a.ce", 32'(if_a.sram_ce_o), 32'(e_we[0]));
      chk("a.we", 32'(if_a.sram_we_o), 32'(e_we[0]));
      chk("b.ce", 32'(if_b.sram_ce_o), 32'(e_we[1]));
      chk("b.we", 32'(if_b.sram_we_o), 32'(e_we[1]));
      if (e_we[0]) begin
        chk("a.addr", if_a.sram_addr_o, 32'(e_addr[0]));
        chk("a.data", if_a.sram_data_o, e_data[0]);
        chk("a.sel",  32'(if_a.sram_sel_o), 32'(e_sel[0]));
      end
      if (e_we[1]) begin
        chk("b.addr", if_b.sram_addr_o, 32'(e_addr[1]));
        chk("b.data", if_b.sram_data_o, e_data[1]);
        chk("b.sel",  32'(if_b.sram_sel_o), 32'(e_sel[1]));
      end
      chk("a.rx_ready", 32'(if_a.rx_ready_o), 32'(e_ready));
      chk("b.rx_ready", 32'(if_b.rx_ready_o), 32'(e_ready));
      chk("a.pkt_valid", 32'(if_a.pkt_valid_o), 32'(e_pv));
      chk("b.pkt_valid", 32'(if_b.pkt_valid_o), 32'(e_pv));
      if (e_pv) begin
        chk("a.pkt_len",   32'(if_a.pkt_len_o),   32'(e_len[0]));
        chk("a.pkt_trunc", 32'(if_a.pkt_trunc_o), 32'(e_trunc[0]));
        chk("b.pkt_len",   32'(if_b.pkt_len_o),   32'(e_len[1]));
        chk("b.pkt_trunc", 32'(if_b.pkt_trunc_o), 32'(e_trunc[1]));
      end
      if (if_a.sram_ce_o) log_a.push_back('{if_a.sram_addr_o, if_a.sram_data_o, if_a.sram_sel_o});
      if (if_b.sram_ce_o) log_b.push_back('{if_b.sram_addr_o, if_b.sram_data_o, if_b.sram_sel_o});
    end
  end

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic pr);
    logic x;
    int t, w;
    logic [31:0] dat;
    logic [3:0] sel;
    @(negedge clk);
    if_a.rx_valid_i = v;  if_b.rx_valid_i = v;
    if_a.rx_data_i  = d;  if_b.rx_data_i  = d;
    if_a.rx_last_i  = l;  if_b.rx_last_i  = l;
    if_a.pkt_ready_i = pr; if_b.pkt_ready_i = pr;
    x = v && m_ready;
    last_xfer = x;
    for (int k = 0; k < 2; k++) e_we[k] = 1'b0;
    if (x) begin
      t = m_t;
      pkt_q.push_back(d);
      m_t++;
      if ((t % 4) == 3 || l) begin
        w = t / 4;
        for (int k = 0; k < 2; k++) begin
          dat = 32'h0;
          sel = 4'h0;
          for (int i = 4 * w; i <= t; i++) begin
            if (i < MAXB[k]) begin
              dat = dat | (32'(pkt_q[i]) << (24 - 8 * (i - 4 * w)));
              sel = sel | (4'b1000 >> (i - 4 * w));
            end
          end
          if (sel != 4'h0) begin
            e_we[k]   = 1'b1;
            e_addr[k] = BASE[k] + 4 * w;
            e_data[k] = dat;
            e_sel[k]  = sel;
          end
        end
      end
      if (l) m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
      e_pv = 1'b1;
      for (int k = 0; k < 2; k++) begin
        e_len[k]   = (m_t > LENMAX[k]) ? LENMAX[k] : m_t;
        e_trunc[k] = (m_t > MAXB[k]);
      end
    end else if (m_phase == 2 && pr) begin
      m_phase = 0;
      e_pv = 1'b0;
      m_t = 0;
      pkt_q.delete();
    end
    e_ready = (m_phase == 0);
    m_ready = e_ready;
  endtask

  // mode 0: valid always high, 1: valid every other cycle, 2: random gaps
  task automatic send_pkt(input int n, input int mode);
    logic v;
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      do begin
        tog = ~tog;
        v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
        cycle(v, tx_q[i], (i == n - 1), 1'b0);
        guard++;
      end while (!last_xfer && guard < 200);
      if (!last_xfer) begin
        errors++;
        $display("FAIL xfer_timeout byte=%0d act=no_transfer exp=transfer", i);
        return;
      end
    end
    guard = 0;
    while (m_phase != 2 && guard < 10) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      guard++;
    end
    // one more cycle so pkt_valid is on the outputs
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic hold_release(input int n, input int bp_mode);
    logic v;
    for (int i = 0; i < n; i++) begin
      v = (bp_mode == 1) ? 1'b1 : (bp_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      cycle(v, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic fill_seq(input int n, input int first);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'(first + i));
  endtask

  task automatic chk_log(input string name, input wr_t q[$], input int idx,
                         input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    if (q.size() > idx) begin
      chk({name, ".addr"}, q[idx].addr, addr);
      chk({name, ".data"}, q[idx].data, data);
      chk({name, ".sel"},  32'(q[idx].sel), 32'(sel));
    end else begin
      chk({name, ".present"}, 32'(q.size()), 32'(idx + 1));
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".a_ce"},    32'(if_a.sram_ce_o), 0);
    chk({name, ".a_we"},    32'(if_a.sram_we_o), 0);
    chk({name, ".a_addr"},  if_a.sram_addr_o, 32'h0);
    chk({name, ".a_sel"},   32'(if_a.sram_sel_o), 0);
    chk({name, ".a_data"},  if_a.sram_data_o, 32'h0);
    chk({name, ".a_pv"},    32'(if_a.pkt_valid_o), 0);
    chk({name, ".a_len"},   32'(if_a.pkt_len_o), 0);
    chk({name, ".a_trunc"}, 32'(if_a.pkt_trunc_o), 0);
    chk({name, ".a_ready"}, 32'(if_a.rx_ready_o), 0);
    chk({name, ".b_addr"},  if_b.sram_addr_o, 32'h100);
    chk({name, ".b_ce"},    32'(if_b.sram_ce_o), 0);
    chk({name, ".b_pv"},    32'(if_b.pkt_valid_o), 0);
    chk({name, ".b_ready"}, 32'(if_b.rx_ready_o), 0);
  endtask

  task automatic do_reset(input string name);
    chk_en = 1'b0;
    if_a.rx_valid_i = 1'b0; if_b.rx_valid_i = 1'b0;
    if_a.pkt_ready_i = 1'b0; if_b.pkt_ready_i = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_vals(name);
    m_ready = 1'b0; m_phase = 0; m_t = 0; pkt_q.delete();
    e_we[0] = 1'b0; e_we[1] = 1'b0; e_pv = 1'b0; e_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    chk_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    if_a.rx_valid_i = 1'b0; if_a.rx_data_i = 8'h00; if_a.rx_last_i = 1'b0; if_a.pkt_ready_i = 1'b0;
    if_b.rx_valid_i = 1'b0; if_b.rx_data_i = 8'h00; if_b.rx_last_i = 1'b0; if_b.pkt_ready_i = 1'b0;
    @(negedge clk);
    do_reset("reset");

    // 14-byte packet 00..0D, gapless
    fill_seq(14, 0);
    log_a.delete(); log_b.delete();
    send_pkt(14, 0);
    chk("p14.nwr", 32'(log_a.size()), 4);
    chk_log("p14.w0", log_a, 0, 32'h0, 32'h00010203, 4'b1111);
    chk_log("p14.w1", log_a, 1, 32'h4, 32'h04050607, 4'b1111);
    chk_log("p14.w2", log_a, 2, 32'h8, 32'h08090A0B, 4'b1111);
    chk_log("p14.w3", log_a, 3, 32'hC, 32'h0C0D0000, 4'b1100);
    chk("p14.len", 32'(if_a.pkt_len_o), 14);
    chk("p14.b_len_sat", 32'(if_b.pkt_len_o), 14);
    chk("p14.b_trunc", 32'(if_b.pkt_trunc_o), 1);

    // back-pressure while the buffer is held
    log_a.delete();
    hold_release(10, 1);
    chk("bp.nwr", 32'(log_a.size()), 0);
    chk("bp.pv_after", 32'(if_a.pkt_valid_o), 0);
    chk("bp.ready_after", 32'(if_a.rx_ready_o), 1);

    // 1-byte packet AB
    tx_q.delete(); tx_q.push_back(8'hAB);
    log_a.delete();
    send_pkt(1, 0);
    chk("p1.nwr", 32'(log_a.size()), 1);
    chk_log("p1.w0", log_a, 0, 32'h0, 32'hAB000000, 4'b1000);
    chk("p1.len", 32'(if_a.pkt_len_o), 1);
    hold_release(2, 0);

    // gappy 8-byte packet; exactly fills dut_b's buffer
    fill_seq(8, 0);
    log_a.delete(); log_b.delete();
    send_pkt(8, 1);
    chk("gap.nwr", 32'(log_a.size()), 2);
    chk_log("gap.w0", log_a, 0, 32'h0, 32'h00010203, 4'b1111);
    chk_log("gap.w1", log_a, 1, 32'h4, 32'h04050607, 4'b1111);
    chk("gap.len", 32'(if_a.pkt_len_o), 8);
    chk_log("gap.b_w1", log_b, 1, 32'h104, 32'h04050607, 4'b1111);
    chk("gap.b_trunc", 32'(if_b.pkt_trunc_o), 0);
    hold_release(1, 0);

    // 10-byte packet truncated in dut_b
    fill_seq(10, 8'h30);
    log_b.delete();
    send_pkt(10, 0);
    chk("tr.b_nwr", 32'(log_b.size()), 2);
    chk_log("tr.b_w0", log_b, 0, 32'h100, 32'h30313233, 4'b1111);
    chk_log("tr.b_w1", log_b, 1, 32'h104, 32'h34353637, 4'b1111);
    chk("tr.b_len", 32'(if_b.pkt_len_o), 10);
    chk("tr.b_trunc", 32'(if_b.pkt_trunc_o), 1);
    hold_release(3, 2);

    // 20 bytes: dut_b's 4-bit counter saturates
    fill_seq(20, 8'h50);
    send_pkt(20, 2);
    chk("sat.b_len", 32'(if_b.pkt_len_o), 15);
    chk("sat.a_len", 32'(if_a.pkt_len_o), 20);
    hold_release(1, 0);

    // reset after the 6th byte, then a 4-byte packet
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    @(negedge clk);
    do_reset("midrst");
    fill_seq(4, 8'hC0);
    log_a.delete();
    send_pkt(4, 0);
    chk("rst4.nwr", 32'(log_a.size()), 1);
    chk_log("rst4.w0", log_a, 0, 32'h0, 32'hC0C1C2C3, 4'b1111);
    chk("rst4.len", 32'(if_a.pkt_len_o), 4);
    hold_release(0, 0);

    // randomized packets
    for (int p = 0; p < 30; p++) begin
      int n;
      n = $urandom_range(1, 40);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      send_pkt(n, 2);
      hold_release($urandom_range(0, 5), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog act=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
